// File: rtl/haar_integral_image_gen_if.sv
// haar_integral_image_gen_if: pixel-in / integral-word-out stream bundle; out_sq exists only with HAAR_SQ_INTEGRAL_EN
interface haar_integral_image_gen_if #(
  parameter int SUM_W = 32
`ifdef HAAR_SQ_INTEGRAL_EN
  , parameter int SQ_W = 40
`endif
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_data;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
`ifdef HAAR_SQ_INTEGRAL_EN
  logic [SQ_W-1:0]  out_sq;
`endif
  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
`ifdef HAAR_SQ_INTEGRAL_EN
    , input out_sq
`endif
  );
  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
`ifdef HAAR_SQ_INTEGRAL_EN
    , output out_sq
`endif
  );
endinterface

// File: rtl/haar_integral_image_gen.sv
// haar_integral_image_gen: streaming integral image, one registered word per raster pixel
// HAAR_SQ_INTEGRAL_EN adds the squared-integral path (out_sq, second row accumulator and line buffer)
module haar_integral_image_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int SUM_W      = 32
`ifdef HAAR_SQ_INTEGRAL_EN
  , parameter int SQ_W     = 40
`endif
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  haar_integral_image_gen_if.slave  s,
  output logic                      sof_err,
  output logic                      busy
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  logic [XW-1:0]    x_q, x_d, xe;
  logic [YW-1:0]    y_q, y_d, ye;
  logic [SUM_W-1:0] row_acc_q, row_acc_d, rs, above, ii, out_data_q, out_data_d;
  logic             first_row_q, first_row_d, waiting_q, waiting_d, busy_q, busy_d;
  logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
  logic             out_eof_q, out_eof_d, sof_err_q, sof_err_d;
  logic             acc, take, fre, eol, eof;
  logic [SUM_W-1:0] lbuf [IMG_WIDTH];
  assign s.in_ready  = ~out_valid_q | s.out_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_sof   = out_sof_q;
  assign s.out_eol   = out_eol_q;
  assign s.out_eof   = out_eof_q;
  assign sof_err     = sof_err_q;
  assign busy        = busy_q;
  // an accepted sof always restarts at (0,0) on a fresh first row, aborting any frame in flight
  always_comb begin
    acc         = s.in_valid & s.in_ready;
    take        = acc & (s.in_sof | ~waiting_q);
    xe          = s.in_sof ? '0 : x_q;
    ye          = s.in_sof ? '0 : y_q;
    fre         = s.in_sof | first_row_q;
    eol         = xe == XW'(IMG_WIDTH - 1);
    eof         = eol & (ye == YW'(IMG_HEIGHT - 1));
    rs          = (xe == '0 ? '0 : row_acc_q) + SUM_W'(s.in_data);
    above       = fre ? '0 : lbuf[xe];
    ii          = above + rs;
    x_d         = take ? (eol ? '0 : xe + 1'b1) : x_q;
    y_d         = take ? (eof ? '0 : eol ? ye + 1'b1 : ye) : y_q;
    first_row_d = take ? (eof | (fre & ~eol)) : first_row_q;
    waiting_d   = take ? eof : waiting_q;
    row_acc_d   = take ? rs : row_acc_q;
    out_valid_d = take | (out_valid_q & ~s.out_ready);
    out_data_d  = take ? ii : out_data_q;
    out_sof_d   = take ? (xe == '0 && ye == '0) : out_sof_q;
    out_eol_d   = take ? eol : out_eol_q;
    out_eof_d   = take ? eof : out_eof_q;
    sof_err_d   = acc & s.in_sof & ~waiting_q;
    busy_d      = (acc & s.in_sof) | (busy_q & ~(out_valid_q & s.out_ready & out_eof_q));
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      row_acc_q   <= '0;
      first_row_q <= 1'b1;
      waiting_q   <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      row_acc_q   <= row_acc_d;
      first_row_q <= first_row_d;
      waiting_q   <= waiting_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      sof_err_q   <= sof_err_d;
    end
  end
  // read-before-write: the async read above sees the previous row's value
  always_ff @(posedge clk_clk) begin
    if (take) lbuf[xe] <= ii;
  end
`ifdef HAAR_SQ_INTEGRAL_EN
  logic [SQ_W-1:0] row_sq_q, row_sq_d, sq_rs, sq_ii, out_sq_q, out_sq_d;
  logic [15:0]     px_sq;
  logic [SQ_W-1:0] lsq [IMG_WIDTH];
  assign s.out_sq = out_sq_q;
  always_comb begin
    px_sq    = {8'd0, s.in_data} * {8'd0, s.in_data};
    sq_rs    = (xe == '0 ? '0 : row_sq_q) + SQ_W'(px_sq);
    sq_ii    = (fre ? '0 : lsq[xe]) + sq_rs;
    row_sq_d = take ? sq_rs : row_sq_q;
    out_sq_d = take ? sq_ii : out_sq_q;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      row_sq_q <= '0;
      out_sq_q <= '0;
    end else begin
      row_sq_q <= row_sq_d;
      out_sq_q <= out_sq_d;
    end
  end
  always_ff @(posedge clk_clk) begin
    if (take) lsq[xe] <= sq_ii;
  end
`endif
endmodule

// File: tb/tb_haar_integral_image_gen.sv
// tb_haar_integral_image_gen: random-stimulus bench with a summed-area reference model on a 4x3 image
module tb_haar_integral_image_gen;
  localparam int W = 4, H = 3, SUM_W = 32, SQ_W = 40;
  typedef struct {
    logic [SUM_W-1:0] d;
    logic [SQ_W-1:0]  sq;
    bit               sof, eol, eof;
  } item_t;
  logic clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic sof_err, busy;
  int errs = 0, checks = 0, err_pulses = 0;
  item_t q[$], lg[$];
  int img[H][W];
  int m_x = 0, m_y = 0;
  bit m_wait = 1, exp_busy = 0, exp_err = 0, rnd_ready = 0;
`ifdef HAAR_SQ_INTEGRAL_EN
  haar_integral_image_gen_if #(.SUM_W(SUM_W), .SQ_W(SQ_W)) s();
  haar_integral_image_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_W(SUM_W), .SQ_W(SQ_W)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .s(s), .sof_err(sof_err), .busy(busy));
`else
  haar_integral_image_gen_if #(.SUM_W(SUM_W)) s();
  haar_integral_image_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_W(SUM_W)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .s(s), .sof_err(sof_err), .busy(busy));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // reference: ii is the plain double sum over the current frame's pixels so far
  task automatic model(input logic [7:0] d, input bit sf);
    item_t it;
    logic [SUM_W-1:0] sd = '0;
    logic [SQ_W-1:0]  ss = '0;
    if (sf) begin
      m_x = 0; m_y = 0; m_wait = 0; exp_busy = 1;
    end else if (m_wait) return;
    img[m_y][m_x] = int'(d);
    for (int j = 0; j <= m_y; j++)
      for (int i = 0; i <= m_x; i++) begin
        sd += SUM_W'(img[j][i]);
        ss += SQ_W'(img[j][i] * img[j][i]);
      end
    it.d = sd; it.sq = ss;
    it.sof = (m_x == 0 && m_y == 0);
    it.eol = (m_x == W - 1);
    it.eof = it.eol && (m_y == H - 1);
    q.push_back(it);
    if (it.eol) begin
      m_x = 0;
      if (it.eof) begin m_y = 0; m_wait = 1; end else m_y++;
    end else m_x++;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit sf, output bit acc);
    @(negedge clk);
    s.in_valid = v; s.in_data = d; s.in_sof = sf;
    s.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1 acc = v && s.in_ready;
    #2 exp_err = acc && sf && !m_wait;
    if (acc) model(d, sf);
  endtask

  task automatic send(input logic [7:0] d, input bit sf);
    bit a;
    int n = 0;
    do begin cycle(1'b1, d, sf, a); n++; end while (!a && n < 100);
    if (!a) begin
      checks++; errs++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    while (q.size() != 0 && n < 200) begin cycle(1'b0, 8'd0, 1'b0, a); n++; end
    cycle(1'b0, 8'd0, 1'b0, a);
    chk("drain", 64'(q.size()), 0);
  endtask

  task automatic ones_frame();
    for (int i = 0; i < W * H; i++) send(8'd1, i == 0);
  endtask

  task automatic check_ones(input int start);
    chk("log_len", 64'(lg.size()), 64'(start + W * H));
    if (lg.size() >= start + W * H)
      for (int i = 0; i < W * H; i++) begin
        chk("ones_data", lg[start + i].d, 64'((i % W + 1) * (i / W + 1)));
        chk("ones_sof", 64'(lg[start + i].sof), 64'(i == 0));
        chk("ones_eol", 64'(lg[start + i].eol), 64'(i % W == W - 1));
        chk("ones_eof", 64'(lg[start + i].eof), 64'(i == W * H - 1));
      end
  endtask

  always begin
    item_t o;
    @(negedge clk);
    #2;
    if (!reset_reset_n) begin
      chk("rst_valid", 64'(s.out_valid), 0);
      chk("rst_data", 64'(s.out_data), 0);
      chk("rst_flags", 64'({s.out_sof, s.out_eol, s.out_eof}), 0);
      chk("rst_sof_err", 64'(sof_err), 0);
      chk("rst_busy", 64'(busy), 0);
`ifdef HAAR_SQ_INTEGRAL_EN
      chk("rst_sq", 64'(s.out_sq), 0);
`endif
    end else begin
      chk("out_valid", 64'(s.out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(s.in_ready), 64'(!(s.out_valid && !s.out_ready)));
      chk("sof_err", 64'(sof_err), 64'(exp_err));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (sof_err) err_pulses++;
      if (s.out_valid && q.size() != 0) begin
        chk("out_data", 64'(s.out_data), 64'(q[0].d));
        chk("out_sof", 64'(s.out_sof), 64'(q[0].sof));
        chk("out_eol", 64'(s.out_eol), 64'(q[0].eol));
        chk("out_eof", 64'(s.out_eof), 64'(q[0].eof));
        o.d = s.out_data; o.sof = s.out_sof; o.eol = s.out_eol; o.eof = s.out_eof; o.sq = '0;
`ifdef HAAR_SQ_INTEGRAL_EN
        chk("out_sq", 64'(s.out_sq), 64'(q[0].sq));
        o.sq = s.out_sq;
`endif
        if (s.out_ready) begin
          lg.push_back(o);
          if (q[0].eof) exp_busy = 0;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    int eofs;
    s.in_valid = 0; s.in_data = 0; s.in_sof = 0; s.out_ready = 1;
    repeat (2) @(negedge clk);
    reset_reset_n = 1;
    // all-ones frame, free-flowing output
    lg.delete();
    ones_frame();
    drain();
    check_ones(0);
    // same frame under random back-pressure
    rnd_ready = 1; lg.delete();
    ones_frame();
    drain();
    check_ones(0);
    // pixels before the first sof are dropped
    rnd_ready = 0; lg.delete();
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    ones_frame();
    drain();
    check_ones(0);
    // sof at (2,1) aborts the frame
    lg.delete(); err_pulses = 0;
    for (int i = 0; i < 6; i++) send(8'd1, i == 0);
    ones_frame();
    drain();
    chk("abort_len", 64'(lg.size()), 64'(6 + W * H));
    if (lg.size() > 6) begin
      chk("abort_word", lg[6].d, 1);
      chk("abort_sof", 64'(lg[6].sof), 1);
    end
    check_ones(6);
    eofs = 0;
    foreach (lg[i]) eofs += int'(lg[i].eof);
    chk("abort_eofs", 64'(eofs), 1);
    chk("abort_err_pulses", 64'(err_pulses), 1);
    // reset at (1,2) while a word is held
    lg.delete();
    for (int i = 0; i < 10; i++) send(8'd1, i == 0);
    @(negedge clk);
    #1 chk("pre_reset_valid", 64'(s.out_valid), 1);
    reset_reset_n = 0; s.in_valid = 0;
    q.delete(); m_wait = 1; m_x = 0; m_y = 0; exp_busy = 0; exp_err = 0;
    repeat (2) @(negedge clk);
    reset_reset_n = 1;
    lg.delete();
    ones_frame();
    drain();
    check_ones(0);
    // random pixels, gaps, back-pressure, stray pixels and occasional aborts
    rnd_ready = 1;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 2)) send(8'($urandom), 1'b0);
      for (int k = 0; k < W * H; k++) begin
        send(8'($urandom), k == 0 || $urandom_range(0, 39) == 0);
        repeat ($urandom_range(0, 1)) cycle(1'b0, 8'd0, 1'b0, a);
      end
    end
    drain();
    // saturated frame
    rnd_ready = 0; lg.delete();
    for (int i = 0; i < W * H; i++) send(8'd255, i == 0);
    drain();
    chk("sat_len", 64'(lg.size()), 64'(W * H));
    if (lg.size() > 0) begin
      chk("sat_last", lg[lg.size() - 1].d, 3060);
      chk("sat_eof", 64'(lg[lg.size() - 1].eof), 1);
`ifdef HAAR_SQ_INTEGRAL_EN
      chk("sat_sq_last", lg[lg.size() - 1].sq, 780300);
`endif
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
